ts_link_monitor: RTL and testbench

- Parametrised successor to the two-link trigger-scintillator register block.
- Monitors NUM_CH 16-bit 8b/10b-decoded trigger-scintillator links: per-channel alignment state machine, saturating error and word counters, shared strobe/ack register interface.
- Link data arrive already synchronised to axi_clk by upstream elastic buffers, so the whole block runs on one clock.
- Sits between the link receivers and the AXI register bridge of the TS subsystem.

---
 rtl/ts_link_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_ts_link_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_link_monitor.sv
// Trigger-scintillator link monitor: per-channel 8b/10b alignment FSM, saturating
// error/word counters and a strobe/ack register interface, all on axi_clk.
module ts_link_monitor #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int DEF_ALIGN  = 45,
    parameter int LOSS_COUNT = 4
) (
    input  logic                  axi_clk,
    input  logic                  reset_n,
    input  logic [2*NUM_CH-1:0]   rx_k,
    input  logic [2*NUM_CH-1:0]   rx_err,
    input  logic [16*NUM_CH-1:0]  rx_d,
    input  logic                  axi_wstr,
    input  logic                  axi_rstr,
    input  logic [7:0]            axi_waddr,
    input  logic [7:0]            axi_raddr,
    input  logic [31:0]           axi_din,
    output logic                  axi_wack,
    output logic                  axi_rack,
    output logic [31:0]           axi_dout,
    output logic [NUM_CH-1:0]     link_up
);

    typedef enum logic [1:0] {
        ST_DOWN     = 2'd0,
        ST_ALIGNING = 2'd1,
        ST_UP       = 2'd2
    } ch_state_t;

    localparam int LW = $clog2(LOSS_COUNT + 1);

    logic [2:0]       wdly;
    logic [4:0]       rdly;
    logic             wr_pulse;
    logic             ctrl_clr;
    logic [7:0]       ctrl_mask;
    logic [11:0]      align_thr;
    logic [11:0]      thr_eff;
    logic [31:0]      rd_data;
    logic             unused_din;

    logic [1:0]       st_arr   [NUM_CH];
    logic [11:0]      run_arr  [NUM_CH];
    logic [CNT_W-1:0] err_arr  [NUM_CH];
    logic [CNT_W-1:0] word_arr [NUM_CH];

    assign unused_din = ^axi_din[31:16];

    // Strobe delay lines; a write fires once, on the third cycle of the strobe.
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            wdly     <= '0;
            rdly     <= '0;
            axi_dout <= '0;
        end else begin
            wdly     <= axi_wstr ? {wdly[1:0], 1'b1} : '0;
            rdly     <= axi_rstr ? {rdly[3:0], 1'b1} : '0;
            axi_dout <= axi_rstr ? rd_data : '0;
        end
    end

    assign wr_pulse = wdly[1] & ~wdly[2];
    assign axi_wack = wdly[2];
    assign axi_rack = rdly[4];

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_clr  <= 1'b0;
            ctrl_mask <= '1;
            align_thr <= 12'(DEF_ALIGN);
        end else begin
            if (wr_pulse && axi_waddr == 8'h00) begin
                ctrl_clr  <= axi_din[0];
                ctrl_mask <= axi_din[15:8];
            end else begin
                ctrl_clr  <= 1'b0;
            end
            if (wr_pulse && axi_waddr == 8'h01)
                align_thr <= axi_din[11:0];
        end
    end

    assign thr_eff = (align_thr == '0) ? 12'd1 : align_thr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]       k;
        logic [1:0]       e;
        logic [15:0]      d;
        logic             en;
        logic             comma;
        logic             errw;
        logic             clean_data;
        logic             unused_hi;
        ch_state_t        st_q;
        logic [11:0]      run_q;
        logic [LW-1:0]    loss_q;
        logic             up_q;
        logic [CNT_W-1:0] err_q;
        logic [CNT_W-1:0] word_q;

        assign k          = rx_k[2*c +: 2];
        assign e          = rx_err[2*c +: 2];
        assign d          = rx_d[16*c +: 16];
        assign unused_hi  = ^d[15:8];
        assign en         = ctrl_mask[c];
        assign errw       = |e;
        assign comma      = (k == 2'b01) && (d[7:0] == 8'hBC) && !errw;
        assign clean_data = (k == 2'b00) && !errw;

        always_ff @(posedge axi_clk or negedge reset_n) begin
            if (!reset_n) begin
                st_q   <= ST_DOWN;
                run_q  <= '0;
                loss_q <= '0;
                up_q   <= 1'b0;
            end else if (!en) begin
                st_q   <= ST_DOWN;
                run_q  <= '0;
                loss_q <= '0;
                up_q   <= 1'b0;
            end else begin
                case (st_q)
                    ST_DOWN: begin
                        if (comma) begin
                            run_q  <= 12'd1;
                            loss_q <= '0;
                            if (thr_eff == 12'd1) begin
                                st_q <= ST_UP;
                                up_q <= 1'b1;
                            end else begin
                                st_q <= ST_ALIGNING;
                            end
                        end
                    end
                    ST_ALIGNING: begin
                        if (errw) begin
                            st_q  <= ST_DOWN;
                            run_q <= '0;
                        end else if (comma) begin
                            run_q <= run_q + 12'd1;
                            if (run_q + 12'd1 >= thr_eff) begin
                                st_q <= ST_UP;
                                up_q <= 1'b1;
                            end
                        end else begin
                            run_q <= '0;
                        end
                    end
                    ST_UP: begin
                        if (errw) begin
                            if (loss_q + LW'(1) == LW'(LOSS_COUNT)) begin
                                st_q   <= ST_DOWN;
                                run_q  <= '0;
                                loss_q <= '0;
                                up_q   <= 1'b0;
                            end else begin
                                loss_q <= loss_q + LW'(1);
                            end
                        end else begin
                            loss_q <= '0;
                        end
                    end
                    default: begin
                        st_q  <= ST_DOWN;
                        run_q <= '0;
                        up_q  <= 1'b0;
                    end
                endcase
            end
        end

        // Clear has priority over any same-cycle increment.
        always_ff @(posedge axi_clk or negedge reset_n) begin
            if (!reset_n) begin
                err_q  <= '0;
                word_q <= '0;
            end else if (ctrl_clr) begin
                err_q  <= '0;
                word_q <= '0;
            end else begin
                if (en && errw && err_q != '1)
                    err_q <= err_q + CNT_W'(1);
                if (st_q == ST_UP && clean_data && word_q != '1)
                    word_q <= word_q + CNT_W'(1);
            end
        end

        assign link_up[c]  = up_q;
        assign st_arr[c]   = st_q;
        assign run_arr[c]  = run_q;
        assign err_arr[c]  = err_q;
        assign word_arr[c] = word_q;
    end

    always_comb begin
        rd_data = '0;
        case (axi_raddr)
            8'h00: rd_data = {16'h0000, ctrl_mask, 7'b0, ctrl_clr};
            8'h01: rd_data = {20'h00000, align_thr};
            8'h02: begin
                rd_data[NUM_CH-1:0] = link_up;
                rd_data[15:8]       = 8'(NUM_CH);
            end
            8'h03: rd_data = 32'hbeef0002;
            default: ;
        endcase
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (axi_raddr == 8'h10 + 8'(c))
                rd_data[CNT_W-1:0] = err_arr[c];
            if (axi_raddr == 8'h20 + 8'(c))
                rd_data[CNT_W-1:0] = word_arr[c];
            if (axi_raddr == 8'h30 + 8'(c))
                rd_data = {4'h0, run_arr[c], 14'h0000, st_arr[c]};
        end
    end

endmodule

// File: tb/tb_ts_link_monitor.sv
// Scoreboarded bench for ts_link_monitor: reads push expected data, a monitor
// compares axi_dout on each rising axi_rack; pin-level checks run inline.
module tb_ts_link_monitor;

    logic        axi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  rx_k = '0;
    logic [3:0]  rx_err = '0;
    logic [31:0] rx_d = '0;
    logic        axi_wstr = 1'b0;
    logic        axi_rstr = 1'b0;
    logic [7:0]  axi_waddr = '0;
    logic [7:0]  axi_raddr = '0;
    logic [31:0] axi_din = '0;
    logic        axi_wack;
    logic        axi_rack;
    logic [31:0] axi_dout;
    logic [1:0]  link_up;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    always #5 axi_clk = ~axi_clk;

    ts_link_monitor #(
        .NUM_CH(2),
        .CNT_W(8),
        .DEF_ALIGN(45),
        .LOSS_COUNT(4)
    ) dut (
        .axi_clk(axi_clk),
        .reset_n(reset_n),
        .rx_k(rx_k),
        .rx_err(rx_err),
        .rx_d(rx_d),
        .axi_wstr(axi_wstr),
        .axi_rstr(axi_rstr),
        .axi_waddr(axi_waddr),
        .axi_raddr(axi_raddr),
        .axi_din(axi_din),
        .axi_wack(axi_wack),
        .axi_rack(axi_rack),
        .axi_dout(axi_dout),
        .link_up(link_up)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // kind 0: clean data word, 1: comma, 2: errored word
    task automatic set_word(input int c, input int kind);
        case (kind)
            1: begin rx_k[2*c +: 2] = 2'b01; rx_err[2*c +: 2] = 2'b00; rx_d[16*c +: 16] = 16'h00BC; end
            2: begin rx_k[2*c +: 2] = 2'b00; rx_err[2*c +: 2] = 2'b01; rx_d[16*c +: 16] = 16'h0000; end
            default: begin rx_k[2*c +: 2] = 2'b00; rx_err[2*c +: 2] = 2'b00; rx_d[16*c +: 16] = 16'h1234; end
        endcase
    endtask

    task automatic send(input int c, input int kind, input int n);
        set_word(c, kind);
        repeat (n) @(posedge axi_clk);
        #1;
        set_word(c, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        int n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        axi_raddr = a;
        axi_rstr  = 1'b1;
        n = 0;
        do begin
            @(posedge axi_clk);
            #1;
            n++;
        end while (!axi_rack && n < 20);
        chk({nm, "_lat"}, n, 5);
        axi_rstr = 1'b0;
        @(posedge axi_clk);
        #1;
        chk({nm, "_idle"}, axi_dout, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] dat, input int hold, input string nm);
        axi_waddr = a;
        axi_din   = dat;
        axi_wstr  = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(posedge axi_clk);
            #1;
            chk({nm, "_wack"}, {31'b0, axi_wack}, {31'b0, i >= 3});
        end
        axi_wstr = 1'b0;
        @(posedge axi_clk);
        #1;
        chk({nm, "_wack_rel"}, {31'b0, axi_wack}, 32'h0);
    endtask

    initial begin : monitor
        logic        rack_prev;
        logic [31:0] exp_v;
        string       nm_v;
        rack_prev = 1'b0;
        forever begin
            @(negedge axi_clk);
            if (axi_rack && !rack_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rack: got %h expected none", axi_dout);
                end else begin
                    exp_v = exp_q.pop_front();
                    nm_v  = name_q.pop_front();
                    checks++;
                    if (axi_dout !== exp_v) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", nm_v, axi_dout, exp_v);
                    end
                end
            end
            rack_prev = axi_rack;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        set_word(0, 0);
        set_word(1, 0);
        repeat (3) @(posedge axi_clk);
        #1;
        chk("rst_link_up", {30'b0, link_up}, 32'h0);
        chk("rst_wack", {31'b0, axi_wack}, 32'h0);
        chk("rst_rack", {31'b0, axi_rack}, 32'h0);
        chk("rst_dout", axi_dout, 32'h0);
        reset_n = 1'b1;
        @(posedge axi_clk);
        #1;

        rd(8'h03, 32'hbeef0002, "id");
        rd(8'h01, 32'd45, "align_rst");
        rd(8'h00, 32'h0000ff00, "ctrl_rst");
        rd(8'h02, 32'h00000200, "status_rst");
        rd(8'h12, 32'h0, "err_ch2_unmapped");
        rd(8'h3f, 32'h0, "unmapped_3f");

        // ch0: 44 commas, then a data word drops run_cnt to 0 while still aligning
        send(0, 1, 44);
        chk("ch0_44_commas", {30'b0, link_up}, 32'h0);
        rd(8'h30, 32'h00000001, "ch0_aligning");
        send(0, 1, 44);
        chk("ch0_44_again", {30'b0, link_up}, 32'h0);
        send(0, 1, 1);
        chk("ch0_up", {30'b0, link_up}, 32'h1);
        rd(8'h30, 32'h002d0002, "ch0_state_up");
        rd(8'h02, 32'h00000201, "status_ch0_up");

        // ch1: loss of link needs LOSS_COUNT consecutive errors
        send(1, 1, 45);
        chk("ch1_up", {30'b0, link_up}, 32'h3);
        send(1, 2, 3);
        chk("ch1_3err", {30'b0, link_up}, 32'h3);
        send(1, 0, 1);
        send(1, 2, 3);
        chk("ch1_3err_again", {30'b0, link_up}, 32'h3);
        send(1, 2, 1);
        chk("ch1_down", {30'b0, link_up}, 32'h1);
        rd(8'h11, 32'd7, "ch1_err7");
        rd(8'h21, 32'd1, "ch1_word1");
        rd(8'h31, 32'h0, "ch1_state_down");

        // saturation and clear
        send(1, 2, 300);
        rd(8'h11, 32'h000000ff, "ch1_err_sat");
        rd(8'h10, 32'h0, "ch0_err0");
        wr(8'h00, 32'h0000ff01, 3, "ctrl_clr");
        rd(8'h11, 32'h0, "ch1_err_cleared");
        rd(8'h00, 32'h0000ff00, "ctrl_selfclr");
        rd(8'h21, 32'h0, "ch1_word_cleared");

        // long strobe: single write, wack from cycle 3
        wr(8'h01, 32'h00000003, 10, "align3");
        rd(8'h01, 32'd3, "align_rd3");
        send(1, 1, 2);
        chk("ch1_2commas", {30'b0, link_up}, 32'h1);
        send(1, 1, 1);
        chk("ch1_up_thr3", {30'b0, link_up}, 32'h3);
        rd(8'h31, 32'h00030002, "ch1_state_thr3");

        // unmapped write ignored
        wr(8'h05, 32'hffffffff, 3, "wr_unmapped");
        rd(8'h05, 32'h0, "rd_unmapped_05");

        // disable ch0 while up
        wr(8'h00, 32'h0000fe00, 3, "mask_fe");
        chk("ch0_disabled", {30'b0, link_up}, 32'h2);
        send(0, 1, 5);
        chk("ch0_commas_ignored", {30'b0, link_up}, 32'h2);
        send(0, 2, 3);
        rd(8'h30, 32'h0, "ch0_state_disabled");
        rd(8'h10, 32'h0, "ch0_err_disabled");
        rd(8'h02, 32'h00000202, "status_mask");
        rd(8'h00, 32'h0000fe00, "ctrl_mask_rd");

        // reset in the middle of a read; strobe held through reset restarts the delay
        exp_q.push_back(32'hbeef0002);
        name_q.push_back("id_after_rst");
        axi_raddr = 8'h03;
        axi_rstr  = 1'b1;
        repeat (3) @(posedge axi_clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_rack", {31'b0, axi_rack}, 32'h0);
        chk("midrst_dout", axi_dout, 32'h0);
        chk("midrst_link_up", {30'b0, link_up}, 32'h0);
        @(posedge axi_clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge axi_clk);
            #1;
            n++;
        end while (!axi_rack && n < 20);
        chk("id_after_rst_lat", n, 5);
        axi_rstr = 1'b0;
        @(posedge axi_clk);
        #1;
        rd(8'h01, 32'd45, "align_after_rst");
        rd(8'h00, 32'h0000ff00, "ctrl_after_rst");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge axi_clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
